// File: rtl/lab3_cache_test_mem_responder.sv
// Memory-side responder for the cache refill/evict port.
// Word-organised backing store with a fixed programmable latency and a
// single outstanding request. Response fields are registered at accept and
// held until the consumer takes them.
module lab3_cache_test_mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [2:0]  memreq_type,
  input  logic [7:0]  memreq_opaque,
  input  logic [31:0] memreq_addr,
  input  logic [1:0]  memreq_len,
  input  logic [31:0] memreq_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [2:0]  memresp_type,
  output logic [7:0]  memresp_opaque,
  output logic [1:0]  memresp_test,
  output logic [1:0]  memresp_len,
  output logic [31:0] memresp_data
);

  localparam int         IDX_W  = $clog2(p_num_words);
  localparam logic [3:0] LAT_M1 = 4'(p_latency - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [3:0]  count_next;

  logic [31:0] mem [p_num_words];

  logic             accept;
  logic             is_write;
  logic [IDX_W-1:0] word_idx;
  logic [4:0]       shamt;
  logic [31:0]      len_mask;
  logic [31:0]      word_rd;
  logic [31:0]      rd_data;
  logic [31:0]      wr_mask;
  logic [31:0]      wr_data;
  logic             unused_addr;

  assign accept      = memreq_val && memreq_rdy;
  assign is_write    = (memreq_type == 3'd1) || (memreq_type == 3'd2);
  assign word_idx    = memreq_addr[IDX_W+1:2];
  assign shamt       = {memreq_addr[1:0], 3'b000};
  assign unused_addr = ^memreq_addr[31:IDX_W+2];

  // Byte-enable mask for the requested length, LSB-aligned (len 0 = 4 bytes)
  always_comb begin
    len_mask = 32'hFFFF_FFFF;
    case (memreq_len)
      2'd1:    len_mask = 32'h0000_00FF;
      2'd2:    len_mask = 32'h0000_FFFF;
      2'd3:    len_mask = 32'h00FF_FFFF;
      default: len_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Shifting by the byte offset naturally drops bytes past the word end
  assign word_rd = mem[word_idx];
  assign rd_data = (word_rd >> shamt) & len_mask;
  assign wr_mask = len_mask << shamt;
  assign wr_data = memreq_data << shamt;

  // Backing store: writes and inits commit on the accept edge, never reset
  always_ff @(posedge clk) begin
    if (accept && is_write)
      mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (wr_data & wr_mask);
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state: an accept (from IDLE or a completing RESP) restarts the latency
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: state_next = IDLE;
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1)
          state_next = RESP;
      end
      RESP: begin
        if (memresp_rdy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      if (p_latency == 1) begin
        state_next = RESP;
      end else begin
        state_next = WAIT;
        count_next = LAT_M1;
      end
    end
  end

  // Handshake outputs; a completing response frees the request port at once
  always_comb begin
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    if (!reset) begin
      memreq_rdy  = (state == IDLE) || ((state == RESP) && memresp_rdy);
      memresp_val = (state == RESP);
    end
  end

  // Response fields captured at accept and held through any backpressure
  always_ff @(posedge clk) begin
    if (accept) begin
      memresp_type   <= memreq_type;
      memresp_opaque <= memreq_opaque;
      memresp_len    <= memreq_len;
      memresp_data   <= is_write ? 32'd0 : rd_data;
    end
  end

  assign memresp_test = 2'b00;

endmodule
